// File: rtl/cypher_pkg.sv
// Shared constants, state encoding and digit helper for the cypher sender.
// Digit 0 is the most significant nibble of the cypher word.
package cypher_pkg;

   localparam int DIGITS    = 4;
   localparam int DIGIT_W   = 4;
   localparam int CYPHER_W  = 16;
   localparam int SUM_W     = 8;
   localparam int MAX_DIGIT = 9;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CHECK  = 2'd1,
      S_SEND   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   // Digit 0 lives in the top nibble, so index from the MSB end.
   function automatic logic [DIGIT_W-1:0] get_digit(input logic [CYPHER_W-1:0] w,
                                                    input logic [1:0]          idx);
      return w[(DIGITS-1-int'(idx))*DIGIT_W +: DIGIT_W];
   endfunction

endpackage

// File: rtl/cypher_digit_check.sv
// Combinational check: flags any nibble of the word that is not a decimal digit.
module cypher_digit_check
   import cypher_pkg::*;
(
   input  logic [CYPHER_W-1:0] i_word,
   output logic                o_bad
);

   localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

   always_comb begin
      o_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i_word[i*DIGIT_W +: DIGIT_W] > MAX_D) o_bad = 1'b1;
      end
   end

endmodule

// File: rtl/cypher_sender.sv
// Sends a latched 16-bit cypher as four decimal digits over a valid/ready port,
// accumulating the sum and count of accepted digits.
module cypher_sender
   import cypher_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic [CYPHER_W-1:0] cypher,
   input  logic                start,
   input  logic                ready,
   output logic [DIGIT_W-1:0]  num,
   output logic                valid,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [SUM_W-1:0]    sum,
   output logic [2:0]          count
);

   state_t              r_state, w_next;
   logic [CYPHER_W-1:0] r_shadow;
   logic [1:0]          r_idx;
   logic [DIGIT_W-1:0]  r_num;
   logic                r_valid;
   logic                r_error;
   logic [SUM_W-1:0]    r_sum;
   logic [2:0]          r_count;
   logic                w_bad;
   logic                w_accept;
   logic                w_last;

   cypher_digit_check u_check (
      .i_word (r_shadow),
      .o_bad  (w_bad)
   );

   assign w_accept = (r_state == S_SEND) && r_valid && ready;
   assign w_last   = (r_idx == 2'(DIGITS-1));

   always_ff @(posedge clock) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_CHECK;
         S_CHECK:  w_next = w_bad ? S_IDLE : S_SEND;
         S_SEND:   if (w_accept && w_last) w_next = S_FINISH;
         S_FINISH: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = (r_state != S_IDLE);
      done  = (r_state == S_FINISH);
      error = r_error;
      num   = r_num;
      valid = r_valid;
      sum   = r_sum;
      count = r_count;
   end

   // Datapath: shadow latch, digit stepping and accumulation.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_shadow <= '0;
         r_idx    <= '0;
         r_num    <= '0;
         r_valid  <= 1'b0;
         r_error  <= 1'b0;
         r_sum    <= '0;
         r_count  <= '0;
      end else begin
         r_error <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shadow <= cypher;
                  r_idx    <= '0;
                  r_sum    <= '0;
                  r_count  <= '0;
               end
            end
            S_CHECK: begin
               if (w_bad) begin
                  r_error <= 1'b1;
               end else begin
                  r_valid <= 1'b1;
                  r_num   <= get_digit(r_shadow, 2'd0);
               end
            end
            S_SEND: begin
               if (w_accept) begin
                  r_sum   <= r_sum + SUM_W'(r_num);
                  r_count <= r_count + 3'd1;
                  r_idx   <= r_idx + 2'd1;
                  if (w_last) r_valid <= 1'b0;
                  else        r_num   <= get_digit(r_shadow, r_idx + 2'd1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cypher_sender.md
CYPHER_SENDER -- requirements
Module: cypher_sender

Interface
REQ-001 The block SHALL have a single clock and a reset that is synchronous and active-low.
REQ-002 Port clock, input, 1: rising-edge clock for all state.
REQ-003 Port reset, input, 1: synchronous active-low reset; 0 at a rising edge resets the block.
REQ-004 Port cypher, input, 16: code to transmit as four 4-bit digits; digit 0 = cypher[15:12], digit 3 = cypher[3:0].
REQ-005 Port start, input, 1: request to transmit; sampled only in IDLE.
REQ-006 Port ready, input, 1: downstream accepts the current digit when valid=1 and ready=1 at a rising edge.
REQ-007 Port num, output, 4: current digit, stable while valid=1 and ready=0.
REQ-008 Port valid, output, 1: num holds a digit that has not yet been accepted.
REQ-009 Port busy, output, 1: high from the start acceptance until the return to IDLE.
REQ-010 Port done, output, 1: one-cycle pulse after the last digit is accepted.
REQ-011 Port error, output, 1: one-cycle pulse when transmission is aborted on a non-decimal digit (>9).
REQ-012 Port sum, output, 8: running sum of accepted digits, zero-extended.
REQ-013 Port count, output, 3: number of digits accepted so far, 0..4.

Function
REQ-014 States SHALL be IDLE, CHECK, SEND, FINISH.
- IDLE -> CHECK when start=1; cypher is latched into a shadow register; sum and count are cleared.
- CHECK -> SEND when all four latched digits are <=9.
- CHECK -> IDLE when any latched digit is >9; error pulses for 1 cycle; valid is never raised.
- SEND -> FINISH on acceptance of digit 3.
- FINISH -> IDLE after 1 cycle, with done=1 during FINISH.
REQ-015 Latency SHALL be: start edge -> CHECK -> valid=1 with digit 0 on the following cycle, i.e. 2 clocks from start to first valid.
REQ-016 In SEND, valid SHALL be 1 continuously.
- On each acceptance, num advances to the next digit on the next cycle, sum += num and count += 1 at that edge.
- Back-to-back acceptance with ready held high SHALL deliver 1 digit per clock.
REQ-017 valid=1 with ready=0 SHALL hold num, sum and count unchanged for any number of cycles.
REQ-018 Changes on cypher after latching SHALL NOT affect the transmission in progress.
REQ-019 start while busy=1 SHALL be ignored; it is not queued.
REQ-020 sum and count SHALL retain their final values in IDLE until the next start acceptance; maximum sum is 36, no overflow handling.
REQ-021 start=1 during the FINISH cycle SHALL be ignored; start=1 in the cycle after FINISH (IDLE) SHALL be accepted.
REQ-022 done and error SHALL never be high in the same cycle.

Reset
REQ-023 reset=0 at a rising edge SHALL force:
- state=IDLE
- num=0, valid=0, busy=0, done=0, error=0, sum=0, count=0
- shadow register cleared
REQ-024 Reset asserted mid-transmission SHALL abort immediately with no done or error pulse; the digit in flight is discarded.

Structure
REQ-025 A shared package/header cypher_pkg SHALL hold:
- DIGITS=4, DIGIT_W=4, CYPHER_W=16, SUM_W=8, MAX_DIGIT=9
- the state encoding constants
cypher_detector SHALL reuse the same package.
REQ-026 One sub-module, cypher_digit_check, SHALL be combinational: it flags any 4-bit field of a 16-bit word greater than MAX_DIGIT.
REQ-027 State, shadow register, digit index, sum and count SHALL all be registered; num and valid SHALL be driven from registers, not combinationally from ready.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- cypher=0x2601, start pulse, ready=1 constant -> num sequence 2,6,0,1 on 4 consecutive valid cycles; done pulses once; sum=9; count=4.
- cypher=0x9999, ready toggling 1,0,0,1,... -> each digit held while ready=0; sum=36; exactly 4 acceptances.
- cypher=0x12A4, start -> error pulse 2 clocks after start; valid never high; busy returns to 0; sum=0.
- cypher=0x3333, start, cypher changed to 0x0000 after the latch -> digits 3,3,3,3 sent; sum=12.
- reset=0 after 2 digits are accepted of 0x5555 -> all outputs 0 at the next edge; no done; the next start with 0x1111 gives sum=4.
- start re-asserted during SEND and during FINISH -> ignored; start the cycle after FINISH -> new transmission begins.
